mult_div_unit: RTL and testbench

Iterative multiply/divide engine that produces the values written into the HiRegister/LoRegister pair. It accepts MULT, MULTU, DIV and DIVU operands from the EX stage. It computes a 64-bit product, or a quotient and remainder, over a fixed number of cycles, then issues a one-cycle write of Hi_Result/Lo_Result onto the Hi/Lo write path (Hi_Enable/Lo_Enable plus PW). Busy drives the hazard unit so that mfhi/mflo stall while an operation is in flight.

---
 rtl/mult_div_unit.sv | 132 +++++++++++++
 tb/tb_mult_div_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide engine feeding the Hi/Lo register pair.
// One radix-2 step per cycle, fixed 34-cycle latency from accept to Done.
module mult_div_unit (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] Rs_Value,
  input  logic [31:0] Rt_Value,
  input  logic        Flush,
  output logic        Busy,
  output logic        Done,
  output logic        HiLo_Write,
  output logic [31:0] Hi_Result,
  output logic [31:0] Lo_Result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state_reg;
  logic [4:0]  counter_reg;
  logic        is_div_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;
  logic [31:0] operand_reg;
  logic [63:0] work_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  logic        signed_op;
  logic        rs_neg;
  logic        rt_neg;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  always_comb begin
    signed_op = ~Op[0];
    rs_neg    = signed_op & Rs_Value[31];
    rt_neg    = signed_op & Rt_Value[31];
    rs_mag    = rs_neg ? (~Rs_Value + 32'd1) : Rs_Value;
    rt_mag    = rt_neg ? (~Rt_Value + 32'd1) : Rt_Value;
  end

  // Shift-add: the low half holds the remaining multiplier bits, the high half the partial sum.
  always_comb begin
    mul_sum  = {1'b0, work_reg[63:32]} + (work_reg[0] ? {1'b0, operand_reg} : 33'd0);
    mul_next = {mul_sum, work_reg[31:1]};
  end

  // Restoring step on the shifted remainder, kept 33 bits wide. If its top bit is set it
  // already exceeds any 32-bit divisor; otherwise bit 32 of the difference is the borrow.
  always_comb begin
    div_diff = work_reg[63:31] - {1'b0, operand_reg};
    div_ge   = work_reg[63] | ~div_diff[32];
    div_next = div_ge ? {div_diff[31:0], work_reg[30:0], 1'b1}
                      : {work_reg[62:0], 1'b0};
  end

  always_comb begin
    prod_fix = neg_q_reg ? (~work_reg + 64'd1) : work_reg;
    quot_fix = neg_q_reg ? (~work_reg[31:0] + 32'd1) : work_reg[31:0];
    rem_fix  = neg_r_reg ? (~work_reg[63:32] + 32'd1) : work_reg[63:32];
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_reg   <= IDLE;
      counter_reg <= 5'd0;
      is_div_reg  <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      operand_reg <= 32'd0;
      work_reg    <= 64'd0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
    end else if (Flush) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (Start) begin
            is_div_reg  <= Op[1];
            neg_q_reg   <= rs_neg ^ rt_neg;
            neg_r_reg   <= rs_neg;
            operand_reg <= rt_mag;
            work_reg    <= {32'd0, rs_mag};
            counter_reg <= 5'd0;
            state_reg   <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          work_reg    <= is_div_reg ? div_next : mul_next;
          counter_reg <= counter_reg + 5'd1;
          if (counter_reg == 5'd31) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          if (is_div_reg) begin
            hi_reg <= rem_fix;
            lo_reg <= quot_fix;
          end else begin
            hi_reg <= prod_fix[63:32];
            lo_reg <= prod_fix[31:0];
          end
          state_reg <= DONE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign Busy       = (state_reg == RUN) || (state_reg == FIX);
  assign Done       = (state_reg == DONE);
  assign HiLo_Write = (state_reg == DONE);
  assign Hi_Result  = hi_reg;
  assign Lo_Result  = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: issued ops push expected Hi/Lo and Done cycle,
// a negedge monitor pops and compares on every HiLo_Write.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        Reset, Start, Flush;
  logic [1:0]  Op;
  logic [31:0] Rs_Value, Rt_Value;
  logic        Busy, Done, HiLo_Write;
  logic [31:0] Hi_Result, Lo_Result;

  mult_div_unit dut (
    .clk(clk), .Reset(Reset), .Start(Start), .Op(Op),
    .Rs_Value(Rs_Value), .Rt_Value(Rt_Value), .Flush(Flush),
    .Busy(Busy), .Done(Done), .HiLo_Write(HiLo_Write),
    .Hi_Result(Hi_Result), .Lo_Result(Lo_Result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;
  int          busy_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (HiLo_Write === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got hi=%h lo=%h required no write", Hi_Result, Lo_Result);
      end else begin
        e = sb.pop_front();
        $display("done %s cyc=%0d hi=%h lo=%h", e.name, cyc, Hi_Result, Lo_Result);
        check({e.name, "_hi"}, {32'd0, Hi_Result}, {32'd0, e.hi});
        check({e.name, "_lo"}, {32'd0, Lo_Result}, {32'd0, e.lo});
        check({e.name, "_done_cycle"}, 64'(cyc), 64'(e.cyc));
        check({e.name, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({e.name, "_done"}, {63'd0, Done}, 64'd1);
      end
      busy_cnt = 0;
    end else if (Busy === 1'b1) begin
      busy_cnt++;
    end else begin
      busy_cnt = 0;
    end
  end

  // Called at a negedge; Start is sampled at the following posedge.
  task automatic issue(input string name, input logic [1:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input bit expect_it,
                       input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    Start    = 1'b1;
    Op       = op;
    Rs_Value = rs;
    Rt_Value = rt;
    if (expect_it) begin
      e.hi   = ehi;
      e.lo   = elo;
      e.cyc  = cyc + 34;
      e.name = name;
      sb.push_back(e);
      last_hi = ehi;
      last_lo = elo;
    end
    $display("issue %s op=%0d rs=%h rt=%h cyc=%0d", name, op, rs, rt, cyc);
    @(negedge clk);
    Start    = 1'b0;
    Rs_Value = $urandom;
    Rt_Value = $urandom;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_one(input string name, input logic [1:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] ehi, input logic [31:0] elo);
    @(negedge clk);
    issue(name, op, rs, rt, 1'b1, ehi, elo);
    drain();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int t;
    Reset = 1'b1; Start = 1'b0; Flush = 1'b0; Op = 2'd0;
    Rs_Value = 32'd0; Rt_Value = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, Busy}, 64'd0);
    check("reset_done", {63'd0, Done}, 64'd0);
    check("reset_write", {63'd0, HiLo_Write}, 64'd0);
    check("reset_hi", {32'd0, Hi_Result}, 64'd0);
    check("reset_lo", {32'd0, Lo_Result}, 64'd0);
    Reset = 1'b0;
    @(negedge clk);

    run_one("mult_neg3x7",   2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run_one("multu_max",     2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_one("mult_m1xm1",    2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
    run_one("div_m7_2",      2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_one("divu_100_7",    2'b11, 32'd100,      32'd7,        32'd2,        32'd14);
    run_one("divu_5_0",      2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);
    run_one("div_min_m1",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_one("div_m7_0",      2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'h00000001);

    // Back-to-back: second Start lands in the Done cycle of the first.
    @(negedge clk);
    issue("div_7_m2", 2'b10, 32'd7, 32'hFFFFFFFE, 1'b1, 32'd1, 32'hFFFFFFFD);
    t = 0;
    while (Done !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("b2b_first_done_seen", {63'd0, Done}, 64'd1);
    issue("multu_b2b", 2'b01, 32'h00010000, 32'h00010000, 1'b1, 32'd1, 32'd0);
    repeat (5) @(negedge clk);
    Start = 1'b1; Op = 2'b11; Rs_Value = 32'd1; Rt_Value = 32'd1;
    @(negedge clk);
    Start = 1'b0;
    drain();

    // Flush at start+10 together with a new Start: nothing accepted, results hold.
    @(negedge clk);
    issue("flushed", 2'b00, 32'd3, 32'd5, 1'b0, 32'd0, 32'd0);
    repeat (9) @(negedge clk);
    Flush = 1'b1; Start = 1'b1; Op = 2'b01; Rs_Value = 32'd2; Rt_Value = 32'd2;
    @(negedge clk);
    Flush = 1'b0; Start = 1'b0;
    check("flush_busy", {63'd0, Busy}, 64'd0);
    check("flush_done", {63'd0, Done}, 64'd0);
    check("flush_hi_hold", {32'd0, Hi_Result}, {32'd0, last_hi});
    check("flush_lo_hold", {32'd0, Lo_Result}, {32'd0, last_lo});
    repeat (40) @(negedge clk);
    check("flush_idle_after", {63'd0, Busy}, 64'd0);

    // Reset at start+20: everything clears and no write follows.
    issue("reset_abort", 2'b11, 32'd50, 32'd3, 1'b0, 32'd0, 32'd0);
    repeat (19) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    check("abort_busy", {63'd0, Busy}, 64'd0);
    check("abort_write", {63'd0, HiLo_Write}, 64'd0);
    check("abort_hi", {32'd0, Hi_Result}, 64'd0);
    check("abort_lo", {32'd0, Lo_Result}, 64'd0);
    repeat (40) @(negedge clk);
    check("abort_idle_after", {63'd0, Busy}, 64'd0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
